lcd_ctrl: RTL

Hardware HD44780-style character-LCD command engine sitting behind the core's LCD I/O register, replacing software bit-banging of the EN/RS/RW/DATA pins. After reset it runs the power-up wait and the fixed init sequence. It then accepts one 9-bit command (RS plus 8-bit data) at a time over a valid/ready handshake from the memory-stage I/O write path. It generates the LCD bus waveform (setup, EN pulse, hold, execution wait) by cycle counting.

---
 rtl/lcd_pkg.sv | 28 ++
 rtl/lcd_timer.sv | 27 ++
 rtl/lcd_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD command engine:
// state encoding, the fixed power-up init ROM and the long-command classifier.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_SETUP,
    ST_EN_HI,
    ST_HOLD,
    ST_WAIT,
    ST_IDLE
  } lcd_state_e;

  localparam int unsigned LCD_INIT_LEN = 4;
  localparam int unsigned LCD_IDX_W    = $clog2(LCD_INIT_LEN);

  // Element 0 is sent first: 8-bit/2-line, display on, clear, entry mode.
  localparam logic [LCD_INIT_LEN-1:0][7:0] LCD_INIT_CMD = {8'h06, 8'h01, 8'h0C, 8'h38};

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  // Home ignores bit 0, so 8'h02 and 8'h03 both take the long execution time.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == LCD_CMD_CLEAR) || ((data & 8'hFE) == LCD_CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter with a zero flag; sticks at zero until reloaded.
module lcd_timer #(
  parameter int unsigned   W       = 8,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= RST_VAL;
    end else if (i_load) begin
      cnt_q <= i_value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// Character-LCD command engine: power-up wait, fixed init sequence, then one
// handshaked command at a time driven onto the LCD bus by cycle counting.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERUP    = 750000,
  parameter int unsigned T_SETUP      = 4,
  parameter int unsigned T_EN_HIGH    = 25,
  parameter int unsigned T_HOLD       = 2,
  parameter int unsigned T_WAIT_SHORT = 2000,
  parameter int unsigned T_WAIT_LONG  = 82000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_cmd_valid,
  input  logic       i_cmd_rs,
  input  logic [7:0] i_cmd_data,
  output logic       o_cmd_ready,
  output logic       o_init_done,
  output logic       o_lcd_on,
  output logic       o_lcd_en,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic [7:0] o_lcd_data
);

  localparam int unsigned MAX_A = (T_POWERUP > T_WAIT_LONG) ? T_POWERUP : T_WAIT_LONG;
  localparam int unsigned MAX_B = (T_WAIT_SHORT > T_EN_HIGH) ? T_WAIT_SHORT : T_EN_HIGH;
  localparam int unsigned MAX_C = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
  localparam int unsigned MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned T_MAX = (MAX_D > MAX_C) ? MAX_D : MAX_C;
  localparam int unsigned CW    = $clog2(T_MAX) + 1;

  // Each state lasts exactly its duration because the counter starts at duration-1.
  localparam logic [CW-1:0] LD_POWERUP    = CW'(T_POWERUP - 1);
  localparam logic [CW-1:0] LD_SETUP      = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_EN_HIGH    = CW'(T_EN_HIGH - 1);
  localparam logic [CW-1:0] LD_HOLD       = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] LD_WAIT_SHORT = CW'(T_WAIT_SHORT - 1);
  localparam logic [CW-1:0] LD_WAIT_LONG  = CW'(T_WAIT_LONG - 1);

  localparam logic [LCD_IDX_W-1:0] LAST_IDX = LCD_IDX_W'(LCD_INIT_LEN - 1);

  lcd_state_e           state_q;
  logic                 ready_q;
  logic                 initDone_q;
  logic                 on_q;
  logic                 en_q;
  logic                 rs_q;
  logic [7:0]           data_q;
  logic [LCD_IDX_W-1:0] initIdx_q;

  logic          timerZero;
  logic          timerLoad;
  logic [CW-1:0] timerValue;
  logic          accept;

  assign accept = i_cmd_valid && ready_q;

  always_comb begin
    timerLoad  = 1'b0;
    timerValue = LD_SETUP;
    case (state_q)
      ST_POWERUP: timerLoad = timerZero;
      ST_SETUP: begin
        timerLoad  = timerZero;
        timerValue = LD_EN_HIGH;
      end
      ST_EN_HI: begin
        timerLoad  = timerZero;
        timerValue = LD_HOLD;
      end
      ST_HOLD: begin
        timerLoad  = timerZero;
        timerValue = is_long_cmd(rs_q, data_q) ? LD_WAIT_LONG : LD_WAIT_SHORT;
      end
      ST_WAIT:  timerLoad = timerZero;
      ST_IDLE:  timerLoad = accept;
      default:  timerLoad = 1'b0;
    endcase
  end

  lcd_timer #(
    .W       (CW),
    .RST_VAL (LD_POWERUP)
  ) u_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (timerLoad),
    .i_value (timerValue),
    .o_zero  (timerZero)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_POWERUP;
      ready_q    <= 1'b0;
      initDone_q <= 1'b0;
      on_q       <= 1'b0;
      en_q       <= 1'b0;
      rs_q       <= 1'b0;
      data_q     <= 8'h00;
      initIdx_q  <= '0;
    end else begin
      on_q <= 1'b1;
      case (state_q)
        ST_POWERUP: begin
          if (timerZero) begin
            state_q   <= ST_SETUP;
            initIdx_q <= '0;
            rs_q      <= 1'b0;
            data_q    <= LCD_INIT_CMD[0];
          end
        end
        ST_SETUP: begin
          if (timerZero) begin
            state_q <= ST_EN_HI;
            en_q    <= 1'b1;
          end
        end
        ST_EN_HI: begin
          if (timerZero) begin
            state_q <= ST_HOLD;
            en_q    <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (timerZero) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (timerZero) begin
            if (initDone_q) begin
              state_q <= ST_IDLE;
              ready_q <= 1'b1;
            end else if (initIdx_q == LAST_IDX) begin
              state_q    <= ST_IDLE;
              ready_q    <= 1'b1;
              initDone_q <= 1'b1;
            end else begin
              state_q   <= ST_SETUP;
              initIdx_q <= initIdx_q + LCD_IDX_W'(1);
              data_q    <= LCD_INIT_CMD[initIdx_q + LCD_IDX_W'(1)];
            end
          end
        end
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_SETUP;
            ready_q <= 1'b0;
            rs_q    <= i_cmd_rs;
            data_q  <= i_cmd_data;
          end
        end
        default: begin
          state_q <= ST_POWERUP;
        end
      endcase
    end
  end

  // Write-only interface: the busy flag is never read back.
  assign o_lcd_rw    = 1'b0;
  assign o_cmd_ready = ready_q;
  assign o_init_done = initDone_q;
  assign o_lcd_on    = on_q;
  assign o_lcd_en    = en_q;
  assign o_lcd_rs    = rs_q;
  assign o_lcd_data  = data_q;

endmodule
